// File: rtl/memory_stage.sv
// MEM stage of the 5-stage RV64 pipeline: issues data-bus loads/stores,
// aligns and extends load data, and stalls upstream while a bus access is open.
package mem_pkg;

    typedef enum logic [1:0] {
        MSIZE1,
        MSIZE2,
        MSIZE4,
        MSIZE8
    } msize_t;

    typedef struct packed {
        logic [31:0] raw_instr;
    } control_t;

    typedef struct packed {
        logic [63:0] pc;
        control_t    ctl;
        logic [63:0] rs2;
        logic [63:0] alu;
        logic        valid;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic [63:0] pc;
        control_t    ctl;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic        valid;
    } memory_data_t;

endpackage

module memory_stage
    import mem_pkg::*;
#(
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    output memory_data_t  dataM_nxt,
    output logic          stall,
    output logic          misalign
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    typedef struct packed {
        logic [63:0] addr;
        msize_t      size;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic        is_load;
        logic        unsgn;
    } req_t;

    logic [0:0]  state;
    req_t        req_q;
    req_t        new_req;
    req_t        cur;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [2:0]  off;
    logic [2:0]  amask;
    logic [7:0]  smask;
    logic        is_load;
    logic        is_store;
    logic        mis;
    logic        active;
    logic        in_txn;
    logic        done;
    logic [63:0] shifted;
    logic [63:0] ext;
    logic        unused_ok;

    assign unused_ok = dresp.addr_ok;

    always_comb begin
        opcode   = dataE.ctl.raw_instr[6:0];
        funct3   = dataE.ctl.raw_instr[14:12];
        off      = dataE.alu[2:0];
        is_load  = (opcode == 7'b0000011);
        is_store = (opcode == 7'b0100011);
        amask    = 3'd0;
        smask    = 8'h00;
        unique case (funct3[1:0])
            2'b00: begin amask = 3'd0; smask = 8'h01; end
            2'b01: begin amask = 3'd1; smask = 8'h03; end
            2'b10: begin amask = 3'd3; smask = 8'h0f; end
            2'b11: begin amask = 3'd7; smask = 8'hff; end
        endcase
        mis = CHECK_ALIGN && (is_load || is_store) && (|(off & amask));
        misalign = reset && dataE.valid && mis;
        active = reset && dataE.valid && (is_load || is_store) && !mis;

        new_req         = '0;
        new_req.addr    = dataE.alu;
        new_req.size    = msize_t'(funct3[1:0]);
        new_req.strobe  = is_store ? (smask << off) : 8'h00;
        new_req.data    = is_store ? (dataE.rs2 << {off, 3'b000}) : 64'd0;
        new_req.is_load = is_load;
        new_req.unsgn   = funct3[2];

        cur    = (state == WAIT) ? req_q : new_req;
        in_txn = reset && ((state == WAIT) || active);
        done   = in_txn && dresp.data_ok;
        stall  = in_txn && !dresp.data_ok;

        dreq = '0;
        if (in_txn) begin
            dreq.valid  = 1'b1;
            dreq.addr   = cur.addr;
            dreq.size   = cur.size;
            dreq.strobe = cur.strobe;
            dreq.data   = cur.data;
        end

        // Bring the addressed bytes down to bit 0, then trim and extend.
        shifted = dresp.data >> {cur.addr[2:0], 3'b000};
        ext     = '0;
        unique case (cur.size)
            MSIZE1: ext = cur.unsgn ? {56'd0, shifted[7:0]}
                                    : {{56{shifted[7]}}, shifted[7:0]};
            MSIZE2: ext = cur.unsgn ? {48'd0, shifted[15:0]}
                                    : {{48{shifted[15]}}, shifted[15:0]};
            MSIZE4: ext = cur.unsgn ? {32'd0, shifted[31:0]}
                                    : {{32{shifted[31]}}, shifted[31:0]};
            MSIZE8: ext = shifted;
        endcase

        dataM_nxt       = '0;
        dataM_nxt.pc    = dataE.pc;
        dataM_nxt.ctl   = dataE.ctl;
        dataM_nxt.alu   = dataE.alu;
        dataM_nxt.valid = in_txn ? done : (reset && dataE.valid);
        dataM_nxt.rdata = (done && cur.is_load) ? ext : 64'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            req_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (active && !dresp.data_ok) begin
                        state <= WAIT;
                        req_q <= new_req;
                    end
                end
                WAIT: begin
                    if (dresp.data_ok) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage: loads, stores, extension,
// wait states, misalignment and asynchronous reset.
module tb_memory_stage;
    import mem_pkg::*;

    logic          clk;
    logic          reset;
    execute_data_t dataE;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;
    memory_data_t  dataM_nxt;
    logic          stall;
    logic          misalign;

    int n_checks;
    int n_fail;

    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    memory_stage #(.CHECK_ALIGN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .dataE     (dataE),
        .dreq      (dreq),
        .dresp     (dresp),
        .dataM_nxt (dataM_nxt),
        .stall     (stall),
        .misalign  (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd1, op};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [63:0] alu,
                         input logic [63:0] rs2, input logic [63:0] pc, input logic v);
        dataE               = '0;
        dataE.ctl.raw_instr = instr;
        dataE.alu           = alu;
        dataE.rs2           = rs2;
        dataE.pc            = pc;
        dataE.valid         = v;
    endtask

    task automatic resp(input logic ok, input logic [63:0] d);
        dresp         = '0;
        dresp.data_ok = ok;
        dresp.data    = d;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        drive(ins(3'b010, OP_LD), 64'h8000_1002, 64'd0, 64'h10, 1'b1);
        resp(1'b1, 64'h55);
        @(negedge clk);
        n_checks++; if (dreq.valid !== 1'b0) begin n_fail++; $display("FAIL rst_dreq_valid got %0b want 0", dreq.valid); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0b want 0", stall); end
        n_checks++; if (dataM_nxt.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", dataM_nxt.valid); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL rst_misalign got %0b want 0", misalign); end
        @(posedge clk); #1;
        drive('0, 64'd0, 64'd0, 64'd0, 1'b0);
        resp(1'b0, 64'd0);
        reset = 1'b1;
    endtask

    task automatic test_ld_wait;
        @(posedge clk); #1;
        drive(ins(3'b011, OP_LD), 64'h8000_1000, 64'd0, 64'h100, 1'b1);
        resp(1'b0, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL ld_stall_c%0d got %0b want 1", i, stall); end
            n_checks++; if (dreq.valid !== 1'b1) begin n_fail++; $display("FAIL ld_dreq_valid_c%0d got %0b want 1", i, dreq.valid); end
            n_checks++; if (dreq.size !== MSIZE8) begin n_fail++; $display("FAIL ld_size_c%0d got %0d want 3", i, dreq.size); end
            n_checks++; if (dreq.addr !== 64'h8000_1000) begin n_fail++; $display("FAIL ld_addr_c%0d got %0h want 80001000", i, dreq.addr); end
            n_checks++; if (dataM_nxt.valid !== 1'b0) begin n_fail++; $display("FAIL ld_valid_c%0d got %0b want 0", i, dataM_nxt.valid); end
            @(posedge clk); #1;
            if (i == 1) dataE.alu = 64'h8000_2000;
        end
        resp(1'b1, 64'h8877_6655_4433_2211);
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ld_done_stall got %0b want 0", stall); end
        n_checks++; if (dataM_nxt.valid !== 1'b1) begin n_fail++; $display("FAIL ld_done_valid got %0b want 1", dataM_nxt.valid); end
        n_checks++; if (dataM_nxt.rdata !== 64'h8877_6655_4433_2211) begin n_fail++; $display("FAIL ld_rdata got %0h want 8877665544332211", dataM_nxt.rdata); end
        @(posedge clk); #1;
        drive('0, 64'd0, 64'd0, 64'd0, 1'b0);
        resp(1'b0, 64'd0);
        @(negedge clk);
        n_checks++; if (dataM_nxt.valid !== 1'b0) begin n_fail++; $display("FAIL ld_after_valid got %0b want 0", dataM_nxt.valid); end
        n_checks++; if (dreq.valid !== 1'b0) begin n_fail++; $display("FAIL ld_after_dreq got %0b want 0", dreq.valid); end
    endtask

    task automatic test_lb_lbu;
        @(posedge clk); #1;
        drive(ins(3'b000, OP_LD), 64'h8000_1003, 64'd0, 64'h104, 1'b1);
        resp(1'b1, 64'h0000_0000_8000_0000);
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lb_stall got %0b want 0", stall); end
        n_checks++; if (dreq.valid !== 1'b1) begin n_fail++; $display("FAIL lb_dreq_valid got %0b want 1", dreq.valid); end
        n_checks++; if (dreq.size !== MSIZE1) begin n_fail++; $display("FAIL lb_size got %0d want 0", dreq.size); end
        n_checks++; if (dreq.strobe !== 8'h00) begin n_fail++; $display("FAIL lb_strobe got %0h want 00", dreq.strobe); end
        n_checks++; if (dataM_nxt.rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL lb_rdata got %0h want ffffffffffffff80", dataM_nxt.rdata); end
        @(posedge clk); #1;
        drive(ins(3'b100, OP_LD), 64'h8000_1003, 64'd0, 64'h108, 1'b1);
        @(negedge clk);
        n_checks++; if (dataM_nxt.valid !== 1'b1) begin n_fail++; $display("FAIL lbu_valid got %0b want 1", dataM_nxt.valid); end
        n_checks++; if (dataM_nxt.rdata !== 64'h80) begin n_fail++; $display("FAIL lbu_rdata got %0h want 80", dataM_nxt.rdata); end
        @(posedge clk); #1;
        drive('0, 64'd0, 64'd0, 64'd0, 1'b0);
        resp(1'b0, 64'd0);
    endtask

    task automatic test_sh;
        @(posedge clk); #1;
        drive(ins(3'b001, OP_ST), 64'h8000_1006, 64'hABCD, 64'h10c, 1'b1);
        resp(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        n_checks++; if (dreq.strobe !== 8'hC0) begin n_fail++; $display("FAIL sh_strobe got %0h want c0", dreq.strobe); end
        n_checks++; if (dreq.data !== 64'hABCD_0000_0000_0000) begin n_fail++; $display("FAIL sh_data got %0h want abcd000000000000", dreq.data); end
        n_checks++; if (dreq.size !== MSIZE2) begin n_fail++; $display("FAIL sh_size got %0d want 1", dreq.size); end
        n_checks++; if (dataM_nxt.rdata !== 64'd0) begin n_fail++; $display("FAIL sh_rdata got %0h want 0", dataM_nxt.rdata); end
        n_checks++; if (dataM_nxt.valid !== 1'b1) begin n_fail++; $display("FAIL sh_valid got %0b want 1", dataM_nxt.valid); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL sh_misalign got %0b want 0", misalign); end
        @(posedge clk); #1;
        drive('0, 64'd0, 64'd0, 64'd0, 1'b0);
        resp(1'b0, 64'd0);
    endtask

    task automatic test_lw_same_cycle;
        @(posedge clk); #1;
        drive(ins(3'b010, OP_LD), 64'h8000_1004, 64'd0, 64'h110, 1'b1);
        resp(1'b1, 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw0_stall got %0b want 0", stall); end
        n_checks++; if (dataM_nxt.valid !== 1'b1) begin n_fail++; $display("FAIL lw0_valid got %0b want 1", dataM_nxt.valid); end
        n_checks++; if (dataM_nxt.rdata !== 64'h1234_5678) begin n_fail++; $display("FAIL lw0_rdata got %0h want 12345678", dataM_nxt.rdata); end
        @(posedge clk); #1;
        drive(ins(3'b010, OP_LD), 64'h8000_1008, 64'd0, 64'h114, 1'b1);
        resp(1'b0, 64'd0);
        @(negedge clk);
        n_checks++; if (dreq.addr !== 64'h8000_1008) begin n_fail++; $display("FAIL lw0_idle_addr got %0h want 80001008", dreq.addr); end
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lw1_stall got %0b want 1", stall); end
        @(posedge clk); #1;
        resp(1'b1, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        n_checks++; if (dataM_nxt.rdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL lw1_rdata got %0h want ffffffffffffffff", dataM_nxt.rdata); end
        n_checks++; if (dataM_nxt.valid !== 1'b1) begin n_fail++; $display("FAIL lw1_valid got %0b want 1", dataM_nxt.valid); end
        @(posedge clk); #1;
        drive('0, 64'd0, 64'd0, 64'd0, 1'b0);
        resp(1'b0, 64'd0);
    endtask

    task automatic test_misalign;
        @(posedge clk); #1;
        drive(ins(3'b010, OP_LD), 64'h8000_1002, 64'd0, 64'h118, 1'b1);
        resp(1'b0, 64'd0);
        @(negedge clk);
        n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL mis_flag got %0b want 1", misalign); end
        n_checks++; if (dreq.valid !== 1'b0) begin n_fail++; $display("FAIL mis_dreq got %0b want 0", dreq.valid); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall got %0b want 0", stall); end
        n_checks++; if (dataM_nxt.valid !== 1'b1) begin n_fail++; $display("FAIL mis_valid got %0b want 1", dataM_nxt.valid); end
        n_checks++; if (dataM_nxt.rdata !== 64'd0) begin n_fail++; $display("FAIL mis_rdata got %0h want 0", dataM_nxt.rdata); end
        @(posedge clk); #1;
        drive('0, 64'd0, 64'd0, 64'd0, 1'b0);
    endtask

    task automatic test_reset_in_wait;
        @(posedge clk); #1;
        drive(ins(3'b011, OP_LD), 64'h8000_3000, 64'd0, 64'h11c, 1'b1);
        resp(1'b0, 64'd0);
        @(posedge clk); #2;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rw_pre_stall got %0b want 1", stall); end
        reset = 1'b0;
        #1;
        n_checks++; if (dreq.valid !== 1'b0) begin n_fail++; $display("FAIL rw_dreq got %0b want 0", dreq.valid); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rw_stall got %0b want 0", stall); end
        n_checks++; if (dataM_nxt.valid !== 1'b0) begin n_fail++; $display("FAIL rw_valid got %0b want 0", dataM_nxt.valid); end
        #1;
        drive('0, 64'd0, 64'd0, 64'd0, 1'b0);
        resp(1'b1, 64'h1234);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (dataM_nxt.valid !== 1'b0) begin n_fail++; $display("FAIL rw_stray_ok_valid got %0b want 0", dataM_nxt.valid); end
        n_checks++; if (dreq.valid !== 1'b0) begin n_fail++; $display("FAIL rw_stray_ok_dreq got %0b want 0", dreq.valid); end
        @(posedge clk); #1;
        drive(ins(3'b000, OP_ALU), 64'h42, 64'd0, 64'h200, 1'b1);
        resp(1'b0, 64'd0);
        @(negedge clk);
        n_checks++; if (dataM_nxt.valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %0b want 1", dataM_nxt.valid); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL add_stall got %0b want 0", stall); end
        n_checks++; if (dreq.valid !== 1'b0) begin n_fail++; $display("FAIL add_dreq got %0b want 0", dreq.valid); end
        n_checks++; if (dataM_nxt.pc !== 64'h200) begin n_fail++; $display("FAIL add_pc got %0h want 200", dataM_nxt.pc); end
        n_checks++; if (dataM_nxt.alu !== 64'h42) begin n_fail++; $display("FAIL add_alu got %0h want 42", dataM_nxt.alu); end
        @(posedge clk); #1;
        drive(ins(3'b011, OP_LD), 64'h8000_4000, 64'd0, 64'h204, 1'b1);
        @(negedge clk);
        n_checks++; if (dreq.addr !== 64'h8000_4000) begin n_fail++; $display("FAIL rw_idle_addr got %0h want 80004000", dreq.addr); end
        @(posedge clk); #1;
        resp(1'b1, 64'hCAFE);
        @(negedge clk);
        n_checks++; if (dataM_nxt.rdata !== 64'hCAFE) begin n_fail++; $display("FAIL rw_ld_rdata got %0h want cafe", dataM_nxt.rdata); end
        @(posedge clk); #1;
        drive('0, 64'd0, 64'd0, 64'd0, 1'b0);
        resp(1'b0, 64'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        dataE    = '0;
        dresp    = '0;
        reset    = 1'b0;
        test_reset();
        test_ld_wait();
        test_lb_lbu();
        test_sh();
        test_lw_same_cycle();
        test_misalign();
        test_reset_in_wait();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
